pl_fetch: RTL and testbench

PL_FETCH -- requirements
Module: PL_FETCH

---
 rtl/pl_fetch_pkg.sv | 32 +++
 rtl/pl_fetch_sat_counter.sv | 36 +++
 rtl/pl_fetch.sv | 106 ++++++++++
 tb/tb_pl_fetch.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pl_fetch_pkg.sv
// Shared ISA package for the fetch and decode stages.
// Holds the fetch sequencer state encoding, the reserved HALT opcode and the
// 5-bit opcode list that IF/ID decodes from instruction bits [15:11].
package pl_fetch_pkg;

  // Fetch sequencer states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } fetch_state_e;

  // Opcode field position and width within a 16-bit instruction word
  localparam int OPCODE_MSB = 15;
  localparam int OPCODE_LSB = 11;

  // Reserved opcode that stops fetch
  localparam logic [4:0] ISA_HALT_OPCODE = 5'b10110;

  // Opcode list shared with IF/ID
  localparam logic [4:0] OP_ADD  = 5'b00000;
  localparam logic [4:0] OP_SUB  = 5'b00001;
  localparam logic [4:0] OP_AND  = 5'b00010;
  localparam logic [4:0] OP_OR   = 5'b00011;
  localparam logic [4:0] OP_XOR  = 5'b00100;
  localparam logic [4:0] OP_LD   = 5'b01000;
  localparam logic [4:0] OP_ST   = 5'b01001;
  localparam logic [4:0] OP_BEQ  = 5'b10000;
  localparam logic [4:0] OP_JMP  = 5'b10001;
  localparam logic [4:0] OP_HALT = ISA_HALT_OPCODE;

endpackage

// File: rtl/pl_fetch_sat_counter.sv
// sat_counter: up-counter that sticks at all-ones instead of wrapping.
// Ports:
//   clk   - clock, rising edge
//   rst   - asynchronous active-high reset, clears the count
//   inc   - add one to the count on the next edge (ignored once saturated)
//   count - current count value
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc && !(&count_q)) begin
      count_d = count_q + {{(WIDTH-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pl_fetch.sv
// pl_fetch: instruction-fetch sequencer (IDLE / RUN / HALT).
// Drives the instruction-memory address, flags which fetched words IF/ID
// must consume, stops on the reserved HALT opcode and follows EX-stage
// redirects (also out of HALT, for a branch still in flight).
// Ports:
//   clk, rst          - clock; asynchronous active-high reset
//   run               - start request, only looked at in IDLE
//   stall             - hold the program counter this cycle
//   branch_taken_EX   - redirect request from EX
//   branch_target_EX  - redirect address
//   instr_mem_out     - instruction word read combinationally at prog_ctr
//   prog_ctr          - instruction-memory address
//   fetch_valid       - word on instr_mem_out is consumed this cycle
//   halted            - fetch stopped on the HALT opcode
//   instr_count       - saturating count of issued instructions
module pl_fetch
  import pl_fetch_pkg::*;
#(
  parameter int         PROG_CTR_WID = 10,
  parameter logic [4:0] HALT_OPCODE  = ISA_HALT_OPCODE
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    run,
  input  logic                    stall,
  input  logic                    branch_taken_EX,
  input  logic [PROG_CTR_WID-1:0] branch_target_EX,
  input  logic [15:0]             instr_mem_out,
  output logic [PROG_CTR_WID-1:0] prog_ctr,
  output logic                    fetch_valid,
  output logic                    halted,
  output logic [15:0]             instr_count
);

  fetch_state_e            state_q;
  fetch_state_e            state_d;
  logic [PROG_CTR_WID-1:0] pc_q;
  logic [PROG_CTR_WID-1:0] pc_d;
  logic                    issue;
  logic                    is_halt_word;
  logic [10:0]             unused_operand_bits;

  // Only the opcode field matters to fetch; the operand bits belong to IF/ID.
  assign is_halt_word        = (instr_mem_out[OPCODE_MSB:OPCODE_LSB] == HALT_OPCODE);
  assign unused_operand_bits = instr_mem_out[10:0];

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    issue   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (run) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        // Branch beats stall beats HALT detect beats sequential increment.
        if (branch_taken_EX) begin
          pc_d = branch_target_EX;
        end else if (stall) begin
          pc_d = pc_q;
        end else if (is_halt_word) begin
          state_d = ST_HALT;
        end else begin
          pc_d  = pc_q + {{(PROG_CTR_WID-1){1'b0}}, 1'b1};
          issue = 1'b1;
        end
      end
      ST_HALT: begin
        if (branch_taken_EX) begin
          pc_d    = branch_target_EX;
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  sat_counter #(
    .WIDTH(16)
  ) u_instr_count (
    .clk  (clk),
    .rst  (rst),
    .inc  (issue),
    .count(instr_count)
  );

  assign prog_ctr    = pc_q;
  assign halted      = (state_q == ST_HALT);
  // The only output with a combinational input path: a stall kills the fetch.
  assign fetch_valid = (state_q == ST_RUN) && !stall;

endmodule

// File: tb/tb_pl_fetch.sv
// Self-checking bench for pl_fetch: directed vectors with literal expected
// values plus a behavioural model compared on every falling edge.
module tb_pl_fetch;

  localparam int PCW = 10;
  localparam int MEMSZ = 1 << PCW;
  localparam logic [15:0] ADD_WORD  = 16'h0123;
  localparam logic [15:0] HALT_WORD = 16'hB000;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           run = 1'b0;
  logic           stall = 1'b0;
  logic           br = 1'b0;
  logic [PCW-1:0] tgt = '0;
  logic [15:0]    imem_out;
  logic [PCW-1:0] prog_ctr;
  logic           fetch_valid;
  logic           halted;
  logic [15:0]    instr_count;

  logic [15:0] mem [MEMSZ];

  // Stand-alone narrow counter to reach saturation in a few cycles
  logic       sc_rst = 1'b0;
  logic       sc_inc = 1'b0;
  logic [3:0] sc_count;

  int checks = 0;
  int errors = 0;

  // Behavioural model: mode 0 = idle, 1 = running, 2 = halted
  int m_mode = 0;
  int m_pc   = 0;
  int m_cnt  = 0;

  always #5 clk = ~clk;

  assign imem_out = mem[prog_ctr];

  pl_fetch #(
    .PROG_CTR_WID(PCW),
    .HALT_OPCODE (5'b10110)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .run             (run),
    .stall           (stall),
    .branch_taken_EX (br),
    .branch_target_EX(tgt),
    .instr_mem_out   (imem_out),
    .prog_ctr        (prog_ctr),
    .fetch_valid     (fetch_valid),
    .halted          (halted),
    .instr_count     (instr_count)
  );

  sat_counter #(
    .WIDTH(4)
  ) u_sc (
    .clk  (clk),
    .rst  (sc_rst),
    .inc  (sc_inc),
    .count(sc_count)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: the word at the model's own address decides the next step.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_mode = 0;
      m_pc   = 0;
      m_cnt  = 0;
    end else begin
      if (m_mode == 0) begin
        if (run) m_mode = 1;
      end else if (m_mode == 1) begin
        if (br) m_pc = int'(tgt);
        else if (!stall) begin
          if (mem[m_pc][15:11] == 5'b10110) m_mode = 2;
          else begin
            m_pc  = (m_pc + 1) % MEMSZ;
            m_cnt = (m_cnt == 65535) ? 65535 : m_cnt + 1;
          end
        end
      end else begin
        if (br) begin
          m_pc   = int'(tgt);
          m_mode = 1;
        end
      end
    end
  end

  // Compare process: every falling edge, outputs against the model
  always @(negedge clk) begin
    chk("model_pc", int'(prog_ctr), m_pc);
    chk("model_valid", int'(fetch_valid), int'(m_mode == 1 && !stall));
    chk("model_halted", int'(halted), int'(m_mode == 2));
    chk("model_count", int'(instr_count), m_cnt);
  end

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #2;
    end
  endtask

  initial begin
    for (int a = 0; a < MEMSZ; a++) mem[a] = ADD_WORD;

    // Asynchronous reset with no clock edge needed
    #1 rst = 1'b1;
    #1;
    chk("rst_pc", int'(prog_ctr), 0);
    chk("rst_valid", int'(fetch_valid), 0);
    chk("rst_halted", int'(halted), 0);
    chk("rst_count", int'(instr_count), 0);
    step(2);
    rst = 1'b0;

    // IDLE ignores branches
    br = 1'b1; tgt = 10'd5;
    step(2);
    chk("idle_pc", int'(prog_ctr), 0);
    chk("idle_valid", int'(fetch_valid), 0);
    br = 1'b0;

    // Run pulse, then sequential fetch 0,1,2,3
    run = 1'b1;
    step(1);
    run = 1'b0;
    chk("run_pc0", int'(prog_ctr), 0);
    chk("run_valid", int'(fetch_valid), 1);
    step(1);
    chk("run_pc1", int'(prog_ctr), 1);
    step(2);
    chk("run_pc3", int'(prog_ctr), 3);
    chk("run_cnt3", int'(instr_count), 3);

    // Branch with simultaneous stall at pc 5: branch wins
    step(2);
    chk("pre_br_pc", int'(prog_ctr), 5);
    br = 1'b1; tgt = 10'h200; stall = 1'b1;
    #1 chk("stall_kills_valid", int'(fetch_valid), 0);
    step(1);
    chk("br_over_stall_pc", int'(prog_ctr), 10'h200);
    chk("br_over_stall_cnt", int'(instr_count), 5);

    // Redirect to 7, then two stall cycles
    stall = 1'b0; tgt = 10'd7;
    step(1);
    br = 1'b0;
    chk("br_pc7", int'(prog_ctr), 7);
    chk("br_not_counted", int'(instr_count), 5);
    stall = 1'b1;
    step(2);
    chk("stall_pc", int'(prog_ctr), 7);
    chk("stall_cnt", int'(instr_count), 5);
    chk("stall_valid", int'(fetch_valid), 0);
    stall = 1'b0;
    step(1);
    chk("resume_pc", int'(prog_ctr), 8);
    chk("resume_cnt", int'(instr_count), 6);

    // Wrap from all-ones to zero
    br = 1'b1; tgt = 10'h3FF;
    step(1);
    br = 1'b0;
    chk("pc_3ff", int'(prog_ctr), 10'h3FF);
    step(1);
    chk("wrap_pc", int'(prog_ctr), 0);
    chk("wrap_cnt", int'(instr_count), 7);

    // HALT word at address 4
    mem[4] = HALT_WORD;
    step(4);
    chk("at_halt_pc", int'(prog_ctr), 4);
    step(1);
    chk("halt_flag", int'(halted), 1);
    chk("halt_pc", int'(prog_ctr), 4);
    chk("halt_cnt", int'(instr_count), 11);
    chk("halt_valid", int'(fetch_valid), 0);
    run = 1'b1; stall = 1'b1;
    step(2);
    run = 1'b0; stall = 1'b0;
    chk("halt_ignores_run", int'(halted), 1);
    chk("halt_hold_pc", int'(prog_ctr), 4);
    br = 1'b1; tgt = 10'd9;
    step(1);
    br = 1'b0;
    chk("unhalt_pc", int'(prog_ctr), 9);
    chk("unhalt_flag", int'(halted), 0);
    chk("unhalt_cnt", int'(instr_count), 11);
    step(1);
    chk("after_unhalt_pc", int'(prog_ctr), 10);

    // Reset between edges mid-RUN with a redirect pending
    rst = 1'b1; br = 1'b1; tgt = 10'h55;
    #1;
    chk("midrst_pc", int'(prog_ctr), 0);
    chk("midrst_valid", int'(fetch_valid), 0);
    chk("midrst_cnt", int'(instr_count), 0);
    step(1);
    rst = 1'b0; br = 1'b0;
    step(2);
    chk("post_rst_pc", int'(prog_ctr), 0);
    chk("post_rst_valid", int'(fetch_valid), 0);
    run = 1'b1;
    step(1);
    run = 1'b0;
    step(1);
    chk("rerun_pc", int'(prog_ctr), 1);
    chk("rerun_cnt", int'(instr_count), 1);

    // Saturation on the narrow counter instance
    sc_rst = 1'b1;
    #1 sc_rst = 1'b0;
    sc_inc = 1'b1;
    step(14);
    chk("sat_14", int'(sc_count), 14);
    step(1);
    chk("sat_15", int'(sc_count), 15);
    step(3);
    chk("sat_hold", int'(sc_count), 15);
    sc_inc = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
